// File: rtl/mic1_mem_pkg.sv
// Shared types and helpers for the MIC-1 main-memory responder.
package mic1_mem_pkg;

  typedef enum logic {
    LOAD,
    RUN
  } mem_state_t;

  localparam int unsigned WORD_BYTES = 4;

  // Big-endian lane select: offset 0 is the most significant byte.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] offset);
    logic [7:0] b;
    unique case (offset)
      2'd0: b = word[31:24];
      2'd1: b = word[23:16];
      2'd2: b = word[15:8];
      2'd3: b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mic1_mem_array.sv
// Word storage with one posedge write port and two negedge registered read ports.
module mic1_mem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter bit          INIT_ZERO   = 1'b1,
  parameter int unsigned AddrW       = 10
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic             dre_i,
  input  logic [AddrW-1:0] daddr_i,
  input  logic             dok_i,
  output logic [31:0]      drdata_o,
  input  logic             fre_i,
  input  logic [AddrW-1:0] faddr_i,
  input  logic             fok_i,
  output logic [31:0]      frdata_o
);

  // Contents survive reset; the initializer only seeds simulation.
  logic [31:0] mem_q [DEPTH_WORDS] = '{default: (INIT_ZERO ? 32'h0000_0000 : 32'hxxxx_xxxx)};
  logic [31:0] drdata_q;
  logic [31:0] frdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(negedge clk_i) begin
    if (!resetn_i) begin
      drdata_q <= '0;
      frdata_q <= '0;
    end else begin
      if (dre_i) begin
        drdata_q <= dok_i ? mem_q[daddr_i] : '0;
      end
      if (fre_i) begin
        frdata_q <= fok_i ? mem_q[faddr_i] : '0;
      end
    end
  end

  assign drdata_o = drdata_q;
  assign frdata_o = frdata_q;

endmodule

// File: rtl/mic1_main_memory.sv
// MIC-1 main memory: host loader, then word data port and byte fetch port on a shared array.
module mic1_main_memory
  import mic1_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter bit          INIT_ZERO   = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] mem_rdata,
  input  logic [31:0] mem_addr_instr,
  input  logic        mem_fetch,
  output logic [7:0]  mem_rd_instr,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        cpu_run,
  output logic        err
);

  localparam int unsigned AddrW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned LaneBits = $clog2(WORD_BYTES);

  mem_state_t state_q, state_d;
  logic       cpu_run_q, cpu_run_d;
  logic       err_q, err_d;
  logic [LaneBits-1:0] lane_q;

  logic             data_ok, fetch_ok, ld_ok, is_run;
  logic             we, oor;
  logic [AddrW-1:0] waddr;
  logic [31:0]      wdata;
  logic [31:0]      fword;

  // Full-width compares so high address bits cannot alias into the array.
  assign data_ok  = mem_addr < 32'(DEPTH_WORDS);
  assign ld_ok    = ld_addr < 32'(DEPTH_WORDS);
  assign fetch_ok = mem_addr_instr[31:LaneBits] < (32 - LaneBits)'(DEPTH_WORDS);
  assign is_run   = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    waddr   = mem_addr[AddrW-1:0];
    wdata   = mem_wdata;
    oor     = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (ld_valid) begin
          we    = ld_ok;
          waddr = ld_addr[AddrW-1:0];
          wdata = ld_data;
          oor   = !ld_ok;
          if (ld_last) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        we  = mem_write && data_ok;
        oor = ((mem_read || mem_write) && !data_ok) || (mem_fetch && !fetch_ok);
      end
      default: state_d = LOAD;
    endcase
    we        = we && resetn;
    cpu_run_d = is_run;
    err_d     = err_q || oor;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= LOAD;
      cpu_run_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_run_q <= cpu_run_d;
      err_q     <= err_d;
    end
  end

  // Lane offset is captured alongside the fetch word so both hold together.
  always_ff @(negedge clk) begin
    if (!resetn) begin
      lane_q <= '0;
    end else if (is_run && mem_fetch) begin
      lane_q <= mem_addr_instr[LaneBits-1:0];
    end
  end

  mic1_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .INIT_ZERO  (INIT_ZERO),
    .AddrW      (AddrW)
  ) u_array (
    .clk_i   (clk),
    .resetn_i(resetn),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .dre_i   (is_run && mem_read),
    .daddr_i (mem_addr[AddrW-1:0]),
    .dok_i   (data_ok),
    .drdata_o(mem_rdata),
    .fre_i   (is_run && mem_fetch),
    .faddr_i (mem_addr_instr[AddrW+LaneBits-1:LaneBits]),
    .fok_i   (fetch_ok),
    .frdata_o(fword)
  );

  assign mem_rd_instr = byte_lane(fword, lane_q);
  assign ld_ready     = (state_q == LOAD);
  assign cpu_run      = cpu_run_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mic1_main_memory.sv
// Directed bench for mic1_main_memory: load, fetch, read/write, range errors, reset.
module tb_mic1_main_memory;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] mem_addr, mem_wdata, mem_addr_instr, ld_addr, ld_data;
  logic        mem_read, mem_write, mem_fetch, ld_valid, ld_last;
  logic [31:0] mem_rdata;
  logic [7:0]  mem_rd_instr;
  logic        ld_ready, cpu_run, err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] fetch_exp [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

  always #5 clk = ~clk;

  mic1_main_memory #(
    .DEPTH_WORDS(1024),
    .INIT_ZERO  (1'b1)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_rdata     (mem_rdata),
    .mem_addr_instr(mem_addr_instr),
    .mem_fetch     (mem_fetch),
    .mem_rd_instr  (mem_rd_instr),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .ld_last       (ld_last),
    .cpu_run       (cpu_run),
    .err           (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_fetch = 1'b0;
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_addr_instr = '0; ld_addr = '0; ld_data = '0;
    idle();
    step();
    step();
    resetn = 1'b1;
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_instr", {24'h0, mem_rd_instr}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_cpu_run", {31'h0, cpu_run}, 32'h0);
    check("rst_ld_ready", {31'h0, ld_ready}, 32'h1);

    // Loader: two words, last on the second.
    ld_valid = 1'b1; ld_addr = 32'd0; ld_data = 32'h1122_3344; ld_last = 1'b0;
    step();
    check("ld_ready_mid", {31'h0, ld_ready}, 32'h1);
    ld_addr = 32'd1; ld_data = 32'hAABB_CCDD; ld_last = 1'b1;
    step();
    check("ld_ready_fall", {31'h0, ld_ready}, 32'h0);
    check("cpu_run_not_yet", {31'h0, cpu_run}, 32'h0);
    idle();
    step();
    check("cpu_run_rise", {31'h0, cpu_run}, 32'h1);

    // Byte fetch PC 0..7, big-endian lanes.
    mem_fetch = 1'b1;
    for (int pc = 0; pc < 8; pc++) begin
      mem_addr_instr = 32'(pc);
      step();
      check($sformatf("fetch_pc%0d", pc), {24'h0, mem_rd_instr}, {24'h0, fetch_exp[pc]});
    end
    mem_fetch = 1'b0;
    step();
    check("fetch_hold", {24'h0, mem_rd_instr}, 32'h0000_00DD);

    // Write then read.
    mem_addr = 32'd976; mem_wdata = 32'h5555_5555; mem_write = 1'b1;
    step();
    mem_addr = 32'd5; mem_wdata = 32'hDEAD_BEEF;
    step();
    mem_write = 1'b0; mem_read = 1'b1;
    step();
    check("rd_after_wr", mem_rdata, 32'hDEAD_BEEF);

    // Simultaneous read/write: old data, then new.
    mem_write = 1'b1; mem_wdata = 32'h0000_0001;
    step();
    check("rw_same_old", mem_rdata, 32'hDEAD_BEEF);
    mem_write = 1'b0;
    step();
    check("rw_same_new", mem_rdata, 32'h0000_0001);
    mem_read = 1'b0;
    step();
    check("rdata_hold", mem_rdata, 32'h0000_0001);
    check("err_clean", {31'h0, err}, 32'h0);

    // Out-of-range accesses.
    mem_read = 1'b1; mem_addr = 32'd1024;
    step();
    check("oor_read", mem_rdata, 32'h0);
    check("oor_err", {31'h0, err}, 32'h1);
    mem_read = 1'b0; mem_fetch = 1'b1; mem_addr_instr = 32'hFFFF_FFFF;
    step();
    check("oor_fetch", {24'h0, mem_rd_instr}, 32'h0);
    mem_fetch = 1'b0; mem_write = 1'b1; mem_addr = 32'd2000; mem_wdata = 32'hCAFE_F00D;
    step();
    mem_write = 1'b0; mem_read = 1'b1; mem_addr = 32'd976;
    step();
    check("oor_write_dropped", mem_rdata, 32'h5555_5555);
    check("err_sticky", {31'h0, err}, 32'h1);

    // Independent read and fetch in one window.
    mem_addr = 32'd0; mem_fetch = 1'b1; mem_addr_instr = 32'd4;
    step();
    check("dual_read", mem_rdata, 32'h1122_3344);
    check("dual_fetch", {24'h0, mem_rd_instr}, 32'h0000_00AA);

    // Reset in RUN.
    idle();
    resetn = 1'b0;
    step();
    step();
    check("rr_cpu_run", {31'h0, cpu_run}, 32'h0);
    check("rr_ld_ready", {31'h0, ld_ready}, 32'h1);
    check("rr_err", {31'h0, err}, 32'h0);
    check("rr_rdata", mem_rdata, 32'h0);
    check("rr_instr", {24'h0, mem_rd_instr}, 32'h0);
    resetn = 1'b1;

    // Core requests are ignored while loading.
    mem_read = 1'b1; mem_write = 1'b1; mem_addr = 32'd0; mem_wdata = 32'hBAD0_BAD0;
    mem_fetch = 1'b1; mem_addr_instr = 32'd0;
    step();
    check("load_ign_rdata", mem_rdata, 32'h0);
    check("load_ign_instr", {24'h0, mem_rd_instr}, 32'h0);
    idle();

    // Reload only the last word at addr 9.
    ld_valid = 1'b1; ld_last = 1'b1; ld_addr = 32'd9; ld_data = 32'h0000_0099;
    step();
    idle();
    step();
    check("reload_cpu_run", {31'h0, cpu_run}, 32'h1);
    mem_read = 1'b1; mem_addr = 32'd0;
    step();
    check("preserved_addr0", mem_rdata, 32'h1122_3344);
    mem_addr = 32'd9;
    step();
    check("reload_addr9", mem_rdata, 32'h0000_0099);
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
